seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Multi-cycle unsigned restoring divider for the execute stage.
- Answers the valid/done handshake the execute stage drives for DIV/DIVU.
- Execute holds `valid` high with operand magnitudes on `a`/`b`, and stalls the pipeline while `valid & ~done`.
- Execute applies signs to `c` itself.
- Result packing: `c[2*WIDTH-1:WIDTH]` = remainder (HI), `c[WIDTH-1:0]` = quotient (LO).

Parameters:
- WIDTH, 32, operand width; `c` is 2*WIDTH bits.
- STEPS_PER_CYCLE, 1, quotient bits resolved per clock. Legal values: 1, 2, 4. Must divide WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- valid  input  1  request; held high by execute until the cycle `done` is seen.
- a  input  WIDTH  dividend (unsigned magnitude); stable while valid & ~done.
- b  input  WIDTH  divisor (unsigned magnitude); stable while valid & ~done.
- done  output  1  result valid this cycle; single-cycle pulse.
- c  output  2*WIDTH  {remainder, quotient}; meaningful only when done=1.
- busy  output  1  high in BUSY state (debug/perf counter).

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; done=0; busy=0; c=0; internal remainder/quotient/divisor/counter cleared.
  - Reset dominates all other inputs in the same cycle, including mid-operation: the in-flight op is discarded and no done is produced.
- States:
  - IDLE: valid=1 → load rem=0, quo=a, dvs=b, cnt=WIDTH/STEPS_PER_CYCLE; go to BUSY. valid=0 → stay.
  - BUSY: each cycle perform STEPS_PER_CYCLE restoring steps:
    - {rem,quo} shifted left by 1.
    - Trial = rem − dvs, computed at WIDTH+1 bits.
    - If trial is non-negative: rem=trial, quo[0]=1; else quo[0]=0.
    - cnt decrements; at cnt==1 → DONE.
    - valid=0 in BUSY → abort to IDLE with no done pulse. This is the flush/exception case.
  - DONE: done=1; c={rem,quo} from registers (no combinational path from a/b to c). Unconditionally → IDLE next cycle.
- Latency: valid first sampled high in IDLE at edge N → done=1 during cycle N+1+WIDTH/STEPS_PER_CYCLE. Default: 33 cycles after request accepted.
- done is registered-state decode only; never combinational on valid.
- Back-to-back:
  - Execute advances on the done cycle.
  - valid still high in the cycle after DONE is a new request and is accepted from IDLE.
  - One bubble (IDLE cycle) between operations is required.
- valid low during DONE: done still asserted (harmless, ignored by execute); state → IDLE.
- c holds its last value outside DONE. Verification checks c only when done=1.
- Divide by zero (b=0): no special path. Algorithm yields quo=all ones, rem=a. Latency unchanged, no exception.
- a < b: quo=0, rem=a.
- Arithmetic: rem register is WIDTH bits; subtraction carry is kept at WIDTH+1 bits so dvs ≥ 2^(WIDTH-1) divides correctly.
- Operand changes while busy are ignored; operands are latched at acceptance.

Test Plan:
- 100/7: valid=1, a=100, b=7 from IDLE → done exactly 33 cycles after acceptance edge; c=0x00000002_0000000E; busy high 32 cycles.
- Large divisor: a=0xFFFFFFFF, b=0x80000000 → c=0x7FFFFFFF_00000001. Then a=0xFFFFFFFF, b=1 → c=0x00000000_FFFFFFFF.
- Divide by zero: a=5, b=0 → c=0x00000005_FFFFFFFF at normal latency; done pulses once.
- Abort: start 1000/3, drop valid 10 cycles into BUSY → no done. Reassert with a=9, b=3 → full 33-cycle latency, c=0x00000000_00000003.
- Back-to-back: hold valid through done; first a=20/b=6 → c=0x00000002_00000003. Change operands to 7/2 on the cycle after done → second done 34 cycles after first done, c=0x00000001_00000003.
- Reset mid-op: assert reset at BUSY cycle 15 with valid held → done, busy, c all 0 next cycle. Release reset with valid=1 → new op accepted, result correct at full latency.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider for the execute stage.
//
// Execute holds `valid` high with operand magnitudes on a/b and stalls while
// valid & ~done. The result arrives as a one-cycle `done` pulse with
// c = {remainder, quotient}. Dropping `valid` while busy aborts the operation
// without a done pulse. Execute applies signs to the result itself.
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   reset  - synchronous active-high reset
//   valid  - request, held high until the done cycle
//   a      - dividend magnitude (WIDTH bits)
//   b      - divisor magnitude (WIDTH bits)
//   done   - result valid this cycle (single-cycle pulse)
//   c      - {remainder, quotient} (2*WIDTH bits), meaningful when done=1
//   busy   - high while iterating
module seq_divider #(
    parameter int unsigned WIDTH           = 32,
    parameter int unsigned STEPS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   c,
    output logic                 busy
);

    localparam int unsigned ITERS = WIDTH / STEPS_PER_CYCLE;
    localparam int unsigned CNT_W = $clog2(ITERS + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   dvs;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   quo_step;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic               last_iter;

    assign last_iter = (cnt == CNT_W'(1));

    // STEPS_PER_CYCLE chained restoring steps. The shifted partial remainder
    // keeps the bit pushed out of rem, so the trial subtraction is WIDTH+1
    // bits wide and divisors >= 2^(WIDTH-1) resolve correctly; trial[WIDTH]
    // is the borrow (negative trial).
    always_comb begin
        rem_step = rem;
        quo_step = quo;
        shifted  = '0;
        trial    = '0;
        for (int unsigned i = 0; i < STEPS_PER_CYCLE; i++) begin
            shifted  = {rem_step, quo_step[WIDTH-1]};
            trial    = shifted - {1'b0, dvs};
            quo_step = {quo_step[WIDTH-2:0], ~trial[WIDTH]};
            rem_step = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (valid) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (!valid) begin
                    state_next = IDLE;
                end else if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are pure state decode, never a combinational function of valid.
    assign done = (state == DONE);
    assign busy = (state == BUSY);

    // c is loaded on the final iteration edge, so it is already stable from
    // registers throughout the DONE cycle and holds afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem <= '0;
            quo <= '0;
            dvs <= '0;
            cnt <= '0;
            c   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid) begin
                        rem <= '0;
                        quo <= a;
                        dvs <= b;
                        cnt <= CNT_W'(ITERS);
                    end
                end
                BUSY: begin
                    if (valid) begin
                        rem <= rem_step;
                        quo <= quo_step;
                        cnt <= cnt - CNT_W'(1);
                        if (last_iter) begin
                            c <= {rem_step, quo_step};
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider (default parameters).
// Stimulus pushes the hand-computed result and the cycle in which done must
// be visible; an independent monitor pops and compares on every done pulse.
module tb_seq_divider;

    localparam int W = 32;

    logic            clk;
    logic            reset;
    logic            valid;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic            done;
    logic [2*W-1:0]  c;
    logic            busy;

    seq_divider #(
        .WIDTH           (W),
        .STEPS_PER_CYCLE (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .valid (valid),
        .a     (a),
        .b     (b),
        .done  (done),
        .c     (c),
        .busy  (busy)
    );

    typedef struct {
        logic [2*W-1:0] c;
        int             cyc;
        string          name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic prev_done = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc = number of rising edges so far.
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [2*W-1:0] act,
                         input logic [2*W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=0x%h want=0x%h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            check("done_single_pulse", {63'b0, prev_done}, 64'd0);
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done: got=done want=no_done (c=0x%h)", c);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_c"}, c, e.c);
                check({e.name, "_latency"}, 64'(cyc), 64'(e.cyc));
                total--; // the pop itself is not a comparison
            end
        end
        prev_done = done;
    end

    // Request issued at a negedge is accepted at edge cyc+1 (DUT idle);
    // 32 iterations follow, so done is visible after edge acc+32 and is
    // sampled at edge acc+33.
    task automatic push_exp(input string name, input logic [2*W-1:0] ec);
        exp_t e;
        e.c    = ec;
        e.cyc  = cyc + 1 + W;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string name, output int busy_cnt);
        bit seen = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got=no_done want=done", name);
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic [2*W-1:0] ec,
                          output int busy_cnt);
        @(negedge clk);
        valid = 1'b1;
        a     = av;
        b     = bv;
        push_exp(name, ec);
        wait_done(name, busy_cnt);
        valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int bc;
        reset = 1'b1;
        valid = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("reset_done", {63'b0, done}, 64'd0);
        check("reset_busy", {63'b0, busy}, 64'd0);
        check("reset_c", c, 64'd0);
        reset = 1'b0;

        run_op("div_100_7", 32'd100, 32'd7, 64'h00000002_0000000E, bc);
        check("busy_cycles", 64'(bc), 64'd32);

        run_op("big_divisor", 32'hFFFFFFFF, 32'h80000000, 64'h7FFFFFFF_00000001, bc);
        run_op("div_by_one", 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, bc);
        run_op("div_by_zero", 32'd5, 32'd0, 64'h00000005_FFFFFFFF, bc);
        run_op("a_lt_b", 32'd3, 32'd10, 64'h00000003_00000000, bc);

        // Abort: drop valid 10 cycles into BUSY; no done may follow.
        @(negedge clk);
        valid = 1'b1;
        a     = 32'd1000;
        b     = 32'd3;
        repeat (11) @(negedge clk);
        valid = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_low", {63'b0, busy}, 64'd0);
        run_op("after_abort_9_3", 32'd9, 32'd3, 64'h00000000_00000003, bc);

        // Back-to-back with valid held through done; new operands appear the
        // cycle after done, accepted one bubble later (34 cycles after done).
        @(negedge clk);
        valid = 1'b1;
        a     = 32'd20;
        b     = 32'd6;
        push_exp("b2b_first", 64'h00000002_00000003);
        wait_done("b2b_first", bc);
        @(posedge clk);
        #1;
        a = 32'd7;
        b = 32'd2;
        push_exp("b2b_second", 64'h00000001_00000003);
        wait_done("b2b_second", bc);
        valid = 1'b0;
        repeat (2) @(negedge clk);

        // Reset mid-operation with valid held high.
        valid = 1'b1;
        a     = 32'd1000;
        b     = 32'd3;
        repeat (16) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_done", {63'b0, done}, 64'd0);
        check("midreset_busy", {63'b0, busy}, 64'd0);
        check("midreset_c", c, 64'd0);
        reset = 1'b0;
        a     = 32'd50;
        b     = 32'd7;
        push_exp("after_reset_50_7", 64'h00000001_00000007);
        wait_done("after_reset_50_7", bc);
        valid = 1'b0;
        repeat (40) @(negedge clk);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
